// File: rtl/simple16_mem_arb.sv
// simple16_mem_arb
// Shares the single-port synchronous Simple16 memory between the instruction
// fetch path (f_*) and the load/store path (d_*). Data accesses win contention
// until MAX_DATA_BURST consecutive contended data grants have been issued, then
// fetch is forced through. Read data returns exactly one cycle after the grant.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   f_req/f_addr          fetch request and address
//   f_gnt                 fetch accepted this cycle (combinational)
//   f_rvalid/f_rdata      fetch response, one cycle after f_gnt
//   d_req/d_we/d_addr/d_wdata  data request, store flag, address, store data
//   d_gnt                 data accepted this cycle (combinational)
//   d_rvalid/d_rdata      load response, one cycle after a load grant
//   mem_en/mem_we/mem_addr/mem_wdata  memory port controls (combinational)
//   mem_rdata             memory read data, valid the cycle after mem_en
//   stall_cnt             saturating count of cycles fetch waited
module simple16_mem_arb #(
    parameter int unsigned AW             = 16,
    parameter int unsigned DW             = 16,
    parameter int unsigned MAX_DATA_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   stall_cnt
);

    localparam int unsigned   BW        = $clog2(MAX_DATA_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);

    localparam logic [1:0] RESP_NONE  = 2'd0;
    localparam logic [1:0] RESP_FETCH = 2'd1;
    localparam logic [1:0] RESP_LOAD  = 2'd2;

    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_nxt;
    logic [1:0]    resp_sel;
    logic [1:0]    resp_nxt;
    logic [15:0]   stall_nxt;
    logic          burst_limit;

    // Grant selection: data first unless the burst limit forces a fetch.
    always_comb begin
        burst_limit = (burst_cnt == BURST_MAX);
        f_gnt       = 1'b0;
        d_gnt       = 1'b0;
        if (!rst) begin
            if (d_req && !(f_req && burst_limit)) begin
                d_gnt = 1'b1;
            end else if (f_req) begin
                f_gnt = 1'b1;
            end
        end
    end

    // Memory port mux; idle port drives zeros.
    always_comb begin
        mem_en    = f_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (f_gnt) begin
            mem_addr = f_addr;
        end else if (d_gnt) begin
            mem_addr = d_addr;
        end
        if (mem_we) begin
            mem_wdata = d_wdata;
        end
    end

    // Next-state for burst counter, response tracker and stall counter.
    always_comb begin
        burst_nxt = burst_cnt;
        resp_nxt  = RESP_NONE;
        stall_nxt = stall_cnt;

        // Only data grants that actually made fetch wait count toward the burst.
        if (d_gnt && f_req) begin
            if (!burst_limit) begin
                burst_nxt = burst_cnt + BW'(1);
            end
        end else if (f_gnt || !f_req) begin
            burst_nxt = '0;
        end

        if (f_gnt) begin
            resp_nxt = RESP_FETCH;
        end else if (d_gnt && !d_we) begin
            resp_nxt = RESP_LOAD;
        end

        if (f_req && !f_gnt && (stall_cnt != 16'hFFFF)) begin
            stall_nxt = stall_cnt + 16'd1;
        end
    end

    // State registers; reset drops any in-flight response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt <= '0;
            resp_sel  <= RESP_NONE;
            stall_cnt <= '0;
        end else begin
            burst_cnt <= burst_nxt;
            resp_sel  <= resp_nxt;
            stall_cnt <= stall_nxt;
        end
    end

    // Responses: valid flags decode the registered selector, data is gated.
    always_comb begin
        f_rvalid = (resp_sel == RESP_FETCH);
        d_rvalid = (resp_sel == RESP_LOAD);
        f_rdata  = f_rvalid ? mem_rdata : '0;
        d_rdata  = d_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_simple16_mem_arb.sv
// Testbench for simple16_mem_arb: table-driven single-cycle vectors plus
// hand-written sequences for contention, fetch drop, async reset and
// stall-counter saturation (second instance with a long burst limit).
module tb_simple16_mem_arb;

    logic        clk;
    logic        rst;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [15:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [15:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] stall_cnt;

    logic        rst_sat;
    logic        s_f_gnt, s_f_rvalid, s_d_gnt, s_d_rvalid, s_mem_en, s_mem_we;
    logic [15:0] s_f_rdata, s_d_rdata, s_mem_addr, s_mem_wdata, s_stall_cnt;

    int checks = 0;
    int errors = 0;

    simple16_mem_arb #(.AW(16), .DW(16), .MAX_DATA_BURST(4)) u_dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
    );

    // Permanently contended instance used only for stall saturation.
    simple16_mem_arb #(.AW(16), .DW(16), .MAX_DATA_BURST(255)) u_sat (
        .clk(clk), .rst(rst_sat),
        .f_req(1'b1), .f_addr(16'h0000), .f_gnt(s_f_gnt),
        .f_rvalid(s_f_rvalid), .f_rdata(s_f_rdata),
        .d_req(1'b1), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
        .d_gnt(s_d_gnt), .d_rvalid(s_d_rvalid), .d_rdata(s_d_rdata),
        .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .mem_rdata(16'h0000), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory model with a bench preload port.
    logic [15:0] mem [0:255];
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    typedef struct {
        logic        f_req;
        logic [15:0] f_addr;
        logic        d_req;
        logic        d_we;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic        e_f_gnt;
        logic        e_d_gnt;
        logic [15:0] e_mem_addr;
        logic        e_mem_we;
        logic [15:0] e_mem_wdata;
        logic        e_f_rvalid;
        logic [15:0] e_f_rdata;
        logic        e_d_rvalid;
        logic [15:0] e_d_rdata;
        logic [15:0] e_stall;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fr, input logic [15:0] fa, input logic dr,
                         input logic dw, input logic [15:0] da, input logic [15:0] dd);
        f_req   = fr;
        f_addr  = fa;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dd;
    endtask

    initial begin
        logic exp_f;
        // Rows: inputs, then expected grants/mem port/responses/stall before the edge.
        vecs[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000,
                    1'b1, 1'b0, 16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'd0};
        vecs[1] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                    1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hABCD, 1'b0, 16'h0000, 16'd0};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h1234,
                    1'b0, 1'b1, 16'h0020, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'd0};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'hFFFF,
                    1'b0, 1'b1, 16'h0020, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'd0};
        vecs[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                    1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h1234, 16'd0};
        vecs[5] = '{1'b1, 16'h0011, 1'b1, 1'b0, 16'h0020, 16'h0000,
                    1'b0, 1'b1, 16'h0020, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'd0};
        vecs[6] = '{1'b1, 16'h0011, 1'b0, 1'b0, 16'h0000, 16'h0000,
                    1'b1, 1'b0, 16'h0011, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h1234, 16'd1};
        vecs[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                    1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h5555, 1'b0, 16'h0000, 16'd1};

        rst     = 1'b1;
        rst_sat = 1'b1;
        pre_we  = 1'b0;
        pre_addr = 8'h00;
        pre_data = 16'h0000;
        drive(1'b1, 16'h0010, 1'b1, 1'b1, 16'h0020, 16'h1234);

        // Preload memory while reset holds the arbiter idle.
        @(negedge clk);
        rst_sat  = 1'b0;
        pre_we   = 1'b1; pre_addr = 8'h10; pre_data = 16'hABCD;
        @(negedge clk);
        pre_addr = 8'h11; pre_data = 16'h5555;
        @(negedge clk);
        pre_we   = 1'b0;
        #4;
        chk("rst_f_gnt",    32'(f_gnt),     32'h0);
        chk("rst_d_gnt",    32'(d_gnt),     32'h0);
        chk("rst_mem_en",   32'(mem_en),    32'h0);
        chk("rst_mem_we",   32'(mem_we),    32'h0);
        chk("rst_mem_addr", 32'(mem_addr),  32'h0);
        chk("rst_mem_wdata",32'(mem_wdata), 32'h0);
        chk("rst_f_rvalid", 32'(f_rvalid),  32'h0);
        chk("rst_d_rvalid", 32'(d_rvalid),  32'h0);
        chk("rst_f_rdata",  32'(f_rdata),   32'h0);
        chk("rst_d_rdata",  32'(d_rdata),   32'h0);
        chk("rst_stall",    32'(stall_cnt), 32'h0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].f_req, vecs[i].f_addr, vecs[i].d_req, vecs[i].d_we,
                  vecs[i].d_addr, vecs[i].d_wdata);
            #4;
            chk($sformatf("v%0d_f_gnt", i),    32'(f_gnt),     32'(vecs[i].e_f_gnt));
            chk($sformatf("v%0d_d_gnt", i),    32'(d_gnt),     32'(vecs[i].e_d_gnt));
            chk($sformatf("v%0d_mem_en", i),   32'(mem_en),    32'(vecs[i].e_f_gnt | vecs[i].e_d_gnt));
            chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr),  32'(vecs[i].e_mem_addr));
            chk($sformatf("v%0d_mem_we", i),   32'(mem_we),    32'(vecs[i].e_mem_we));
            chk($sformatf("v%0d_mem_wdata", i),32'(mem_wdata), 32'(vecs[i].e_mem_wdata));
            chk($sformatf("v%0d_f_rvalid", i), 32'(f_rvalid),  32'(vecs[i].e_f_rvalid));
            chk($sformatf("v%0d_f_rdata", i),  32'(f_rdata),   32'(vecs[i].e_f_rdata));
            chk($sformatf("v%0d_d_rvalid", i), 32'(d_rvalid),  32'(vecs[i].e_d_rvalid));
            chk($sformatf("v%0d_d_rdata", i),  32'(d_rdata),   32'(vecs[i].e_d_rdata));
            chk($sformatf("v%0d_stall", i),    32'(stall_cnt), 32'(vecs[i].e_stall));
            @(negedge clk);
        end

        // Mid-cycle reset pulse with no clock edge must clear the stall count.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_stall", 32'(stall_cnt), 32'h0);

        // Contention: D,D,D,D,F,D,D,D,D,F.
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0020, 16'h0000);
            #4;
            exp_f = (k == 4) || (k == 9);
            chk($sformatf("cont%0d_f_gnt", k), 32'(f_gnt), 32'(exp_f));
            chk($sformatf("cont%0d_d_gnt", k), 32'(d_gnt), 32'(!exp_f));
            @(negedge clk);
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #4;
        chk("cont_stall", 32'(stall_cnt), 32'd8);

        // Fetch dropped after two data grants: burst restarts from zero.
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            if (k == 2) drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000);
            else        drive(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0020, 16'h0000);
            #4;
            exp_f = (k == 7);
            chk($sformatf("drop%0d_f_gnt", k), 32'(f_gnt), 32'(exp_f));
            chk($sformatf("drop%0d_d_gnt", k), 32'(d_gnt), 32'(!exp_f));
            @(negedge clk);
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #4;
        chk("drop_stall", 32'(stall_cnt), 32'd14);

        // Reset asserted during a fetch grant cycle: response is dropped.
        @(negedge clk);
        drive(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #2;
        chk("mid_f_gnt_pre", 32'(f_gnt), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_f_gnt_rst",  32'(f_gnt),     32'h0);
        chk("mid_mem_en_rst", 32'(mem_en),    32'h0);
        chk("mid_addr_rst",   32'(mem_addr),  32'h0);
        chk("mid_stall_rst",  32'(stall_cnt), 32'h0);
        @(posedge clk);
        #1;
        chk("mid_f_rvalid_rst", 32'(f_rvalid), 32'h0);
        chk("mid_f_rdata_rst",  32'(f_rdata),  32'h0);
        @(negedge clk);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        rst = 1'b0;
        #4;
        chk("post_f_rvalid", 32'(f_rvalid),  32'h0);
        chk("post_stall",    32'(stall_cnt), 32'h0);
        @(negedge clk);
        drive(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #4;
        chk("post_f_gnt",    32'(f_gnt),    32'h1);
        chk("post_mem_addr", 32'(mem_addr), 32'h0010);
        @(negedge clk);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #4;
        chk("post_f_rvalid2", 32'(f_rvalid), 32'h1);
        chk("post_f_rdata",   32'(f_rdata),  32'hABCD);

        // Saturation: the contended instance stalls 255 of every 256 cycles.
        repeat (66000) @(posedge clk);
        @(negedge clk);
        chk("sat_stall", 32'(s_stall_cnt), 32'hFFFF);
        @(negedge clk);
        chk("sat_stall_hold", 32'(s_stall_cnt), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
